// File: rtl/mem_port_arbiter_if.sv
// Requester and RAM signal bundle for mem_port_arbiter.
// master = arbiter side, slave = requesters plus RAM.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ack;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    logic              stall_if;
    logic              stall_mem;

    modport master (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
        output i_rdata, i_ack, d_rdata, d_ack,
        output ram_en, ram_we, ram_addr, ram_wdata, stall_if, stall_mem
    );

    modport slave (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_rdata,
        input  i_rdata, i_ack, d_rdata, d_ack,
        input  ram_en, ram_we, ram_addr, ram_wdata, stall_if, stall_mem
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port RAM between fetch (I) and load/store (D).
// Define ARB_ROUND_ROBIN_EN for alternating grant on contention; default is D over I.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.master bus,
    output logic               busy
);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    generate
        if (LATENCY < 1) begin : g_bad_latency
            $error("mem_port_arbiter: LATENCY must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;

    state_t            state;
    owner_t            owner;
    owner_t            last_grant;
    logic              cmd_we;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [CNT_W-1:0]  cnt;
    logic              ram_en_q;
    logic              ram_we_q;
    logic              i_ack_q;
    logic              d_ack_q;
    logic [DATA_W-1:0] i_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              grant_d;

    // NOTE: every variable assigned in always_comb gets a default first so no latch can be inferred.
    always_comb begin
        grant_d = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        grant_d = bus.d_req && (!bus.i_req || last_grant == OWN_I);
`else
        grant_d = bus.d_req;
`endif
    end

`ifndef ARB_ROUND_ROBIN_EN
    // Fixed priority keeps last_grant for observability only.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            owner      <= OWN_I;
            last_grant <= OWN_I;
            cmd_we     <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            cnt        <= '0;
            ram_en_q   <= 1'b0;
            ram_we_q   <= 1'b0;
            i_ack_q    <= 1'b0;
            d_ack_q    <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            ram_en_q <= 1'b0;
            ram_we_q <= 1'b0;
            i_ack_q  <= 1'b0;
            d_ack_q  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (bus.i_req || bus.d_req) begin
                        if (grant_d) begin
                            owner     <= OWN_D;
                            cmd_we    <= bus.d_we;
                            cmd_addr  <= bus.d_addr;
                            cmd_wdata <= bus.d_wdata;
                        end else begin
                            owner     <= OWN_I;
                            cmd_we    <= 1'b0;
                            cmd_addr  <= bus.i_addr;
                            cmd_wdata <= '0;
                        end
                        ram_en_q <= 1'b1;
                        ram_we_q <= grant_d & bus.d_we;
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt   <= CNT_W'(LATENCY - 1);
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        // Read data lands exactly LATENCY cycles after the ISSUE strobe.
                        if (owner == OWN_I) begin
                            i_rdata_q <= bus.ram_rdata;
                            i_ack_q   <= 1'b1;
                        end else begin
                            if (!cmd_we) d_rdata_q <= bus.ram_rdata;
                            d_ack_q <= 1'b1;
                        end
                        state <= S_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    last_grant <= owner;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.ram_en    = ram_en_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = cmd_addr;
    assign bus.ram_wdata = cmd_wdata;
    assign bus.i_ack     = i_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.stall_if  = bus.i_req & ~i_ack_q;
    assign bus.stall_mem = bus.d_req & ~d_ack_q;
    assign busy          = (state != S_IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a RAM responder plus a transaction-level
// model of grant order, ack timing (T+LATENCY+2) and memory contents.
module tb_mem_port_arbiter;
    parameter int LATENCY = 2;
    localparam int AW = 32;
    localparam int DW = 32;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(LATENCY)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM contents: ram_mem is the device, ref_mem is the bench's expectation.
    typedef struct { int due; logic [AW-1:0] addr; } rd_t;
    rd_t           pend[$];
    logic [DW-1:0] ram_mem [logic [AW-1:0]];
    logic [DW-1:0] ref_mem [logic [AW-1:0]];
    int            en_count = 0;
    logic [AW-1:0] iss_addr  = '0;
    logic          iss_we    = 1'b0;
    logic [DW-1:0] iss_wdata = '0;
    bit            last_served = 1'b0;  // 1 = D served last

    function automatic logic [DW-1:0] fill(input logic [AW-1:0] a);
        return {a[15:0], 16'hC0DE} ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : fill(a);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // RAM responder: read data is valid only in the cycle LATENCY after ram_en, junk otherwise.
    initial begin
        rd_t e;
        bus.ram_rdata = '0;
        forever begin
            @(posedge clk); #1;
            while (pend.size() > 0 && pend[0].due < cyc) void'(pend.pop_front());
            if (pend.size() > 0 && pend[0].due == cyc) begin
                bus.ram_rdata = ram_mem.exists(pend[0].addr) ? ram_mem[pend[0].addr] : fill(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                bus.ram_rdata = $urandom();
            end
            if (bus.ram_en === 1'b1) begin
                en_count++;
                iss_addr  = bus.ram_addr;
                iss_we    = bus.ram_we;
                iss_wdata = bus.ram_wdata;
                if (bus.ram_we === 1'b1) begin
                    ram_mem[bus.ram_addr] = bus.ram_wdata;
                end else begin
                    e.due  = cyc + LATENCY;
                    e.addr = bus.ram_addr;
                    pend.push_back(e);
                end
            end
        end
    end

    // One access from an idle arbiter; called and returns at +2 after a posedge.
    task automatic access(input bit is_d, input bit we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata);
        int t, exp_ack, en0;
        bit got;
        logic [DW-1:0] exp_rd, d_keep;
        exp_rd = ref_rd(addr);
        d_keep = bus.d_rdata;
        en0    = en_count;
        if (is_d) begin
            bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
        end else begin
            bus.i_req = 1'b1; bus.i_addr = addr;
        end
        t = cyc;
        exp_ack = t + LATENCY + 2;
        got = 1'b0;
        for (int k = 0; k < LATENCY + 8 && !got; k++) begin
            #1;
            check("busy", busy, cyc != t);
            if (is_d) begin
                check("stall_mem", bus.stall_mem, cyc != exp_ack);
                check("no_i_ack", bus.i_ack, 0);
                got = bus.d_ack;
            end else begin
                check("stall_if", bus.stall_if, cyc != exp_ack);
                check("no_d_ack", bus.d_ack, 0);
                got = bus.i_ack;
            end
            if (got) begin
                check("ack_cycle", cyc, exp_ack);
                check("ram_en_pulses", en_count - en0, 1);
                check("ram_addr", iss_addr, addr);
                check("ram_we", iss_we, we);
                if (is_d && we) begin
                    check("ram_wdata", iss_wdata, wdata);
                    check("store_keeps_d_rdata", bus.d_rdata, d_keep);
                end else if (is_d) begin
                    check("d_rdata", bus.d_rdata, exp_rd);
                end else begin
                    check("i_rdata", bus.i_rdata, exp_rd);
                end
                bus.i_req = 1'b0;
                bus.d_req = 1'b0;
            end else begin
                // Input changes mid-access must be ignored.
                if (cyc != t) begin
                    bus.i_addr = $urandom(); bus.d_addr = $urandom(); bus.d_wdata = $urandom();
                end
                @(posedge clk); #2;
            end
        end
        if (!got) check("ack_timeout", 0, 1);
        if (is_d && we) ref_mem[addr] = wdata;
        last_served = is_d;
        @(posedge clk); #2;
        check("ack_one_cycle", is_d ? bus.d_ack : bus.i_ack, 0);
        check("idle_after", busy, 0);
    endtask

    // Simultaneous I and D requests, each held until its own ack.
    task automatic pair(input logic [AW-1:0] ia, input logic [AW-1:0] da, input bit dwe,
                        input logic [DW-1:0] dwd);
        int t, exp_i, exp_d, en0;
        bit first_d, i_got, d_got;
        logic [DW-1:0] exp_i_rd, exp_d_rd, d_keep;
        first_d  = RR ? !last_served : 1'b1;
        exp_i_rd = ref_rd(ia);
        exp_d_rd = ref_rd(da);
        d_keep   = bus.d_rdata;
        en0      = en_count;
        bus.i_req = 1'b1; bus.i_addr = ia;
        bus.d_req = 1'b1; bus.d_we = dwe; bus.d_addr = da; bus.d_wdata = dwd;
        t = cyc;
        exp_d = t + (first_d ? LATENCY + 2 : 2 * LATENCY + 5);
        exp_i = t + (first_d ? 2 * LATENCY + 5 : LATENCY + 2);
        i_got = 1'b0;
        d_got = 1'b0;
        for (int k = 0; k < 2 * LATENCY + 12 && !(i_got && d_got); k++) begin
            #1;
            if (!i_got) begin
                check("pair_stall_if", bus.stall_if, cyc != exp_i);
                if (bus.i_ack === 1'b1) begin
                    i_got = 1'b1;
                    check("pair_i_ack_cycle", cyc, exp_i);
                    check("pair_i_rdata", bus.i_rdata, exp_i_rd);
                    bus.i_req = 1'b0;
                end
            end
            if (!d_got) begin
                check("pair_stall_mem", bus.stall_mem, cyc != exp_d);
                if (bus.d_ack === 1'b1) begin
                    d_got = 1'b1;
                    check("pair_d_ack_cycle", cyc, exp_d);
                    check("pair_d_rdata", bus.d_rdata, dwe ? d_keep : exp_d_rd);
                    bus.d_req = 1'b0;
                end
            end
            if (!(i_got && d_got)) begin
                @(posedge clk); #2;
            end
        end
        if (!(i_got && d_got)) check("pair_timeout", 0, 1);
        check("pair_ram_en_pulses", en_count - en0, 2);
        if (dwe) ref_mem[da] = dwd;
        last_served = !first_d;
        @(posedge clk); #2;
    endtask

    initial begin
        rst = 1'b1;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        ram_mem[32'h40] = 32'hDEAD_BEEF;
        ref_mem[32'h40] = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #2;
        check("rst_busy", busy, 0);
        check("rst_ram_en", bus.ram_en, 0);
        check("rst_ram_we", bus.ram_we, 0);
        check("rst_i_ack", bus.i_ack, 0);
        check("rst_d_ack", bus.d_ack, 0);
        check("rst_ram_addr", bus.ram_addr, 0);
        check("rst_ram_wdata", bus.ram_wdata, 0);
        check("rst_i_rdata", bus.i_rdata, 0);
        check("rst_d_rdata", bus.d_rdata, 0);
        rst = 1'b0;
        @(posedge clk); #2;

        // Directed: single fetch, store, load-back.
        access(1'b0, 1'b0, 32'h40, '0);
        access(1'b1, 1'b1, 32'h100, 32'h1234_5678);
        access(1'b1, 1'b0, 32'h100, '0);

        // Random single accesses; data region 0x100.., fetch region 0x00..
        for (int n = 0; n < 12; n++) begin
            bit is_d, we;
            logic [AW-1:0] a;
            is_d = 1'($urandom_range(0, 1));
            we   = is_d ? 1'($urandom_range(0, 1)) : 1'b0;
            a    = is_d ? AW'(32'h100 + 4 * $urandom_range(0, 7)) : AW'(4 * $urandom_range(0, 15));
            access(is_d, we, a, $urandom());
        end

        // Contention pairs.
        for (int n = 0; n < 4; n++) begin
            pair(AW'(4 * $urandom_range(0, 15)), AW'(32'h100 + 4 * $urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), $urandom());
        end
        // After a D-only access, contention shows the arbitration policy.
        access(1'b1, 1'b0, 32'h104, '0);
        pair(32'h8, 32'h108, 1'b0, '0);

        // Reset during WAIT of a load.
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h100;
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        bus.d_req = 1'b0;
        check("midrst_busy", busy, 0);
        check("midrst_d_ack", bus.d_ack, 0);
        check("midrst_d_rdata", bus.d_rdata, 0);
        check("midrst_i_rdata", bus.i_rdata, 0);
        check("midrst_ram_en", bus.ram_en, 0);
        for (int k = 0; k < LATENCY + 4; k++) begin
            @(posedge clk); #2;
            check("midrst_no_ack", bus.d_ack, 0);
            check("midrst_stays_idle", busy, 0);
        end
        last_served = 1'b0;
        access(1'b1, 1'b0, 32'h100, '0);
        access(1'b0, 1'b0, 32'h40, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences a single-port, fixed-latency RAM shared by the instruction-fetch requester (I) and the load/store requester (D). D is driven by the decoder's mem_read and mem_write outputs.
- Arbitrates between the two, then latches the winning command, issues it, waits out the RAM latency and returns a registered response with a one-cycle ack.
- Generates stall outputs for the IF and MEM stages of the pipeline.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- LATENCY, 2, cycles from the ram_en cycle to valid ram_rdata. Legal range is 1 or more; elaboration fails otherwise.

Ports:
- clk  in  1  the single clock.
- rst  in  1  reset. Synchronous, active-high.
- i_req  in  1  fetch request. Held until i_ack.
- i_addr  in  ADDR_W  fetch address.
- i_rdata  out  DATA_W  fetch data. Registered; valid while i_ack=1.
- i_ack  out  1  fetch done. One-cycle pulse.
- d_req  in  1  data request. Held until d_ack.
- d_we  in  1  1 means store, 0 means load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data. Registered.
- d_ack  out  1  data done. One-cycle pulse.
- ram_en  out  1  RAM command strobe.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data. Valid LATENCY cycles after ram_en.
- stall_if  out  1  equals i_req & ~i_ack (combinational).
- stall_mem  out  1  equals d_req & ~d_ack (combinational).
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE; ram_en, ram_we and both acks are 0; ram_addr, ram_wdata, i_rdata and d_rdata are 0; last_grant=I; wait counter=0.
- State machine: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any request is present, select an owner and latch that owner's addr/we/wdata into the command register, then go to ISSUE.
  - Fetch commands always latch we=0.
  - Default priority: D over I.
- ISSUE (1 cycle):
  - ram_en=1 and ram_we=latched we; ram_addr and ram_wdata come from the command register.
  - Load counter with LATENCY-1, then go to WAIT.
- WAIT (LATENCY cycles):
  - Count down.
  - On the cycle the counter is 0, capture ram_rdata into the owner's rdata register (loads and fetches only), then go to RESP.
- RESP (1 cycle):
  - The owner's ack is 1; update last_grant; go to IDLE.
  - Stores leave d_rdata unchanged.
- Latency: request sampled in IDLE at cycle T gives ack at T+LATENCY+2. Minimum spacing between back-to-back accesses is LATENCY+3 cycles.
- ram_en is high only in ISSUE. Outside ISSUE, ram_we=0.
- Request inputs are ignored outside IDLE. Address and data changes during an access have no effect because the command is latched.
- A req still high in the IDLE cycle after its ack counts as a new request.
- If the owner drops req mid-access, the access still completes and the ack still pulses. The RAM write is not cancelled.
- Simultaneous i_req and d_req in IDLE: D wins and I waits (stall_if stays 1).
- Reset during ISSUE, WAIT or RESP: next state is IDLE, no ack pulses, and the rdata registers clear. A RAM write already issued is not undone.
- rdata registers hold their value between accesses.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- When defined: on a simultaneous request, grant the requester that is not last_grant. last_grant resets to I, so the first contention goes to D. With a single requester, that requester is granted.
- When undefined: fixed priority, D over I. last_grant is still tracked but unused.

Test Plan:
- Single fetch, LATENCY=2: i_req=1 and i_addr=0x40 at cycle 0. Expect ram_en=1 with ram_addr=0x40 at cycle 1. Drive ram_rdata=0xDEADBEEF at cycle 3. Expect i_ack=1 and i_rdata=0xDEADBEEF at cycle 4. stall_if is high for cycles 0-3.
- Store: d_req=1, d_we=1, d_addr=0x100, d_wdata=0x12345678. Expect ram_en=1, ram_we=1 and ram_wdata=0x12345678 in ISSUE. d_ack pulses at T+4 and d_rdata is unchanged.
- Contention, macro off: i_req and d_req both rise at cycle 0 and are held. Expect D served first (d_ack at 4) and I served next (i_ack at 9). Repeat the pair: D is again first.
- Contention, ARB_ROUND_ROBIN_EN on: first pair gives D then I. Second simultaneous pair gives D first, because last_grant=I after the I access. Alternating holds over 4 pairs with i_req held throughout.
- Reset mid-op: assert rst during WAIT of a load. Next cycle: state=IDLE, busy=0, d_ack never pulses, d_rdata=0. A new request issues normally afterwards.
- LATENCY=1 and LATENCY=5 builds: fetch ack arrives at T+3 and T+7 respectively. Each access shows exactly one ram_en pulse.
